ammod_sched: RTL and testbench

Round-robin scheduler that shares one pipelined CORDIC AM modulator (polar-to-Cartesian, fixed latency 5 cycles, no stall input) between four requesters. It accepts (radius, phase) jobs over per-channel valid/ready handshakes and issues at most one job per cycle into the modulator. A matching tag delay line carries each job's channel number alongside its result. Results are collected in an 8-deep output FIFO with valid/ready backpressure. A credit check ensures no issued job can overflow the FIFO.

---
 rtl/ammod_sched.sv | 146 ++++++++++++++
 tb/tb_ammod_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ammod_sched.sv
// ammod_sched: round-robin scheduler sharing one pipelined CORDIC AM modulator
// between four requesters, with an 8-deep show-ahead result FIFO.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid/req_ready [3:0]     per-channel job handshake (req_ready one-hot or 0)
//   req_r/req_phi                 packed per-channel radius/phase, W+1 bits each
//   cordic_r/cordic_phi           registered job operands to the modulator
//   cordic_x/cordic_y/cordic_eps  modulator results, LAT edges after operands
//   out_valid/out_ready           result FIFO head handshake
//   out_ch/out_x/out_y/out_eps    FIFO head contents
//   busy                          jobs in flight or results waiting
module ammod_sched #(
   parameter int unsigned W     = 8,
   parameter int unsigned LAT   = 5,
   parameter int unsigned DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req_valid,
   output logic [3:0]         req_ready,
   input  logic [4*(W+1)-1:0] req_r,
   input  logic [4*(W+1)-1:0] req_phi,
   output logic [W:0]         cordic_r,
   output logic [W:0]         cordic_phi,
   input  logic [W:0]         cordic_x,
   input  logic [W:0]         cordic_y,
   input  logic [W:0]         cordic_eps,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         out_ch,
   output logic [W:0]         out_x,
   output logic [W:0]         out_y,
   output logic [W:0]         out_eps,
   output logic               busy
);

   localparam int unsigned WD = W + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef struct packed {
      logic       vld;
      logic [1:0] ch;
   } tag_t;

   typedef struct packed {
      logic [1:0]    ch;
      logic [WD-1:0] x;
      logic [WD-1:0] y;
      logic [WD-1:0] eps;
   } entry_t;

   logic [1:0]          last_grant;
   logic [1:0]          grant_idx;
   logic [1:0]          idx;
   logic                found;
   logic                can_issue;
   logic                xfer;
   tag_t                new_tag;
   tag_t [LAT:0]        tags;
   logic [CW-1:0]       inflight;
   logic [CW-1:0]       count;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   entry_t [DEPTH-1:0]  mem;
   logic                push;
   logic                pop;

   // Credit: a new job may only start if its result is guaranteed a FIFO slot.
   assign can_issue = (5'(inflight) + 5'(count)) < 5'(DEPTH);

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      grant_idx = last_grant;
      found     = 1'b0;
      idx       = '0;
      req_ready = '0;
      for (int k = 0; k < 4; k++) begin
         idx = last_grant + 2'(k + 1);
         if (!found && req_valid[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
      if (can_issue && found && !reset)
         req_ready[grant_idx] = 1'b1;
   end

   assign xfer    = |(req_valid & req_ready);
   assign new_tag = '{vld: xfer, ch: grant_idx};

   // Issue stage, tag delay line and in-flight counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cordic_r   <= '0;
         cordic_phi <= '0;
         last_grant <= 2'd3;
         tags       <= '0;
         inflight   <= '0;
      end else begin
         if (xfer) begin
            cordic_r   <= req_r[grant_idx*WD +: WD];
            cordic_phi <= req_phi[grant_idx*WD +: WD];
            last_grant <= grant_idx;
         end else begin
            cordic_r   <= '0;
            cordic_phi <= '0;
         end
         tags     <= {tags[LAT-1:0], new_tag};
         inflight <= inflight + CW'(xfer) - CW'(tags[LAT].vld);
      end
   end

   // A tag in the last stage qualifies the modulator output this cycle.
   assign push = tags[LAT].vld;
   assign pop  = out_valid & out_ready;

   // Result FIFO; storage is cleared on reset so the head reads 0 afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            mem[wr_ptr] <= '{ch: tags[LAT].ch, x: cordic_x, y: cordic_y, eps: cordic_eps};
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + CW'(push) - CW'(pop);
      end
   end

   assign out_ch    = mem[rd_ptr].ch;
   assign out_x     = mem[rd_ptr].x;
   assign out_y     = mem[rd_ptr].y;
   assign out_eps   = mem[rd_ptr].eps;
   assign out_valid = (count != '0);
   assign busy      = (inflight != '0) | (count != '0);

   // The credit rule makes a write into a full FIFO without a pop impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_ammod_sched.sv
// Bench for ammod_sched: behavioural LAT-stage modulator stand-in, scoreboard of
// expected results pushed at each transfer and compared at each FIFO pop.
module tb_ammod_sched;

   localparam int unsigned W   = 8;
   localparam int unsigned WD  = W + 1;
   localparam int unsigned LAT = 5;

   typedef struct packed {
      logic [1:0]    ch;
      logic [WD-1:0] x;
      logic [WD-1:0] y;
      logic [WD-1:0] eps;
   } exp_t;

   logic               clk;
   logic               reset;
   logic [3:0]         req_valid;
   logic [3:0]         req_ready;
   logic [4*WD-1:0]    req_r;
   logic [4*WD-1:0]    req_phi;
   logic [W:0]         cordic_r;
   logic [W:0]         cordic_phi;
   logic [W:0]         cordic_x;
   logic [W:0]         cordic_y;
   logic [W:0]         cordic_eps;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         out_ch;
   logic [W:0]         out_x;
   logic [W:0]         out_y;
   logic [W:0]         out_eps;
   logic               busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_xfer   = 0;
   int n_pop    = 0;
   int pop_run  = 0;
   int run_max  = 0;
   exp_t sb[$];

   ammod_sched #(.W(W), .LAT(LAT), .DEPTH(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_r(req_r), .req_phi(req_phi),
      .cordic_r(cordic_r), .cordic_phi(cordic_phi),
      .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_eps(cordic_eps),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_x(out_x), .out_y(out_y), .out_eps(out_eps),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Modulator stand-in: fixed LAT-edge pipeline with a simple bit-exact mapping.
   logic [W:0] px [LAT];
   logic [W:0] py [LAT];
   logic [W:0] pe [LAT];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            px[i] <= '0; py[i] <= '0; pe[i] <= '0;
         end
      end else begin
         px[0] <= WD'(cordic_r + cordic_phi);
         py[0] <= WD'(cordic_r - cordic_phi);
         pe[0] <= cordic_r ^ cordic_phi;
         for (int i = 1; i < LAT; i++) begin
            px[i] <= px[i-1]; py[i] <= py[i-1]; pe[i] <= pe[i-1];
         end
      end
   end
   assign cordic_x   = px[LAT-1];
   assign cordic_y   = py[LAT-1];
   assign cordic_eps = pe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input int ch);
      logic [W:0] r;
      logic [W:0] p;
      exp_t e;
      r     = req_r[ch*WD +: WD];
      p     = req_phi[ch*WD +: WD];
      e.ch  = 2'(ch);
      e.x   = WD'(r + p);
      e.y   = WD'(r - p);
      e.eps = r ^ p;
      return e;
   endfunction

   // Scoreboard monitor, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_pop++;
            pop_run++;
            if (pop_run > run_max) run_max = pop_run;
            if (sb.size() == 0) begin
               chk("spurious_result", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("out_ch", 32'(out_ch), 32'(e.ch));
               chk("out_x", 32'(out_x), 32'(e.x));
               chk("out_y", 32'(out_y), 32'(e.y));
               chk("out_eps", 32'(out_eps), 32'(e.eps));
            end
         end else begin
            pop_run = 0;
         end
         chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));
         for (int ch = 0; ch < 4; ch++) begin
            if (req_valid[ch] && req_ready[ch]) begin
               sb.push_back(model(ch));
               n_xfer++;
            end
         end
      end
   end

   // Advance one cycle and refresh all channel data with random values.
   task automatic step();
      @(posedge clk);
      #1;
      req_r   = {$urandom, $urandom};
      req_phi = {$urandom, $urandom};
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int x0;
      int p0;
      int nv;
      int expg;
      logic [3:0] onehot;

      reset     = 1'b1;
      req_valid = 4'b1111;
      out_ready = 1'b0;
      req_r     = '0;
      req_phi   = '0;
      #3;
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_cordic_r", 32'(cordic_r), 32'(0));
      chk("rst_out_x", 32'(out_x), 32'(0));
      chk("rst_out_ch", 32'(out_ch), 32'(0));
      step(); step();
      reset     = 1'b0;
      req_valid = '0;
      step();

      // Single job on channel 2, idle block
      req_valid = 4'b0100;
      req_r[2*WD +: WD]   = WD'(100);
      req_phi[2*WD +: WD] = '0;
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'(4'b0100));
      step();
      req_valid = '0;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!out_valid && lat < 20);
      chk("single_latency", 32'(lat), 32'(6));
      chk("single_busy", 32'(busy), 32'(1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("single_drained", 32'(out_valid), 32'(0));
      chk("single_idle", 32'(busy), 32'(0));

      // Fairness: all channels requesting, consumer always ready
      step();
      req_valid = 4'b1111;
      out_ready = 1'b1;
      p0        = n_pop;
      run_max   = 0;
      expg      = 3;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         onehot = 4'b0001 << expg;
         chk("rr_grant", 32'(req_ready), 32'(onehot));
         expg = (expg + 1) % 4;
         step();
      end
      req_valid = '0;
      repeat (12) step();
      chk("rr_pops", 32'(n_pop - p0), 32'(12));
      chk("rr_no_gaps", 32'(run_max), 32'(12));

      // Backpressure: FIFO fills to exactly 8 results
      out_ready = 1'b0;
      req_valid = 4'b1111;
      x0 = n_xfer;
      p0 = n_pop;
      repeat (20) step();
      chk("bp_accepted", 32'(n_xfer - x0), 32'(8));
      @(negedge clk);
      chk("bp_stalled", 32'(req_ready), 32'(0));
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_refill", 32'(req_ready != 0), 32'(1));
      // Pop on the same edge the refill result is written
      repeat (6) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("pushpop_head", 32'(out_valid), 32'(1));
      chk("pushpop_refill", 32'(req_ready != 0), 32'(1));
      repeat (10) step();
      chk("bp_total", 32'(n_xfer - x0), 32'(10));
      @(negedge clk);
      chk("bp_stalled2", 32'(req_ready), 32'(0));
      req_valid = '0;
      out_ready = 1'b1;
      repeat (20) step();
      chk("bp_drained", 32'(n_pop - p0), 32'(10));
      chk("bp_sb_empty", 32'(sb.size()), 32'(0));

      // Reset with 3 jobs in flight and 2 results in the FIFO
      out_ready = 1'b0;
      step();
      x0 = n_xfer;
      req_valid = 4'b1111;
      repeat (5) step();
      req_valid = '0;
      repeat (3) step();
      chk("mid_issued", 32'(n_xfer - x0), 32'(5));
      chk("mid_pre_valid", 32'(out_valid), 32'(1));
      chk("mid_pre_busy", 32'(busy), 32'(1));
      reset     = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("mid_out_valid", 32'(out_valid), 32'(0));
      chk("mid_busy", 32'(busy), 32'(0));
      chk("mid_req_ready", 32'(req_ready), 32'(0));
      chk("mid_out_x", 32'(out_x), 32'(0));
      repeat (2) step();
      reset     = 1'b0;
      req_valid = '0;
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid || busy) nv++;
         step();
      end
      chk("post_rst_quiet", 32'(nv), 32'(0));
      req_valid = 4'b1111;
      @(negedge clk);
      chk("post_rst_grant", 32'(req_ready), 32'(4'b0001));
      step();
      req_valid = '0;
      out_ready = 1'b1;
      repeat (15) step();
      chk("final_sb_empty", 32'(sb.size()), 32'(0));
      chk("final_idle", 32'(busy), 32'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
